rs_age: RTL

Parametrised out-of-order reservation station sitting between dispatch/rename and the functional units. It generalises entry count, superscalar width, tag width and functional-unit class count. It issues strictly oldest-ready-first using an age matrix and enforces per-class unit budgets. It also supports ROB-relative squash on branch mispredict.

---
 rtl/rs_age_if.sv | 48 ++++
 rtl/rs_age.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rs_age_if.sv
// Reservation-station bundle: dispatch, CDB, FU budget, squash and issue signals.
interface rs_age_if #(
  parameter int N_ENTRIES = 16,
  parameter int WAYS      = 3,
  parameter int PR_W      = 6,
  parameter int ROB_W     = 5,
  parameter int N_CLASS   = 3,
  parameter int PAYLOAD_W = 128
);
  localparam int CLS_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam int BUD_W = $clog2(WAYS + 1);
  localparam int CNT_W = $clog2(N_ENTRIES + 1);

  logic [WAYS-1:0]                 disp_valid;
  logic [WAYS-1:0]                 disp_ready;
  logic [WAYS-1:0][CLS_W-1:0]      disp_class;
  logic [WAYS-1:0][PR_W-1:0]       disp_src1;
  logic [WAYS-1:0][PR_W-1:0]       disp_src2;
  logic [WAYS-1:0]                 disp_rdy1;
  logic [WAYS-1:0]                 disp_rdy2;
  logic [WAYS-1:0][ROB_W-1:0]      disp_rob;
  logic [WAYS-1:0][PAYLOAD_W-1:0]  disp_payload;
  logic [WAYS-1:0]                 cdb_valid;
  logic [WAYS-1:0][PR_W-1:0]       cdb_tag;
  logic [N_CLASS-1:0][BUD_W-1:0]   fu_budget;
  logic                            squash;
  logic [ROB_W-1:0]                squash_rob;
  logic [ROB_W-1:0]                rob_head;
  logic [WAYS-1:0]                 iss_valid;
  logic [WAYS-1:0][CLS_W-1:0]      iss_class;
  logic [WAYS-1:0][ROB_W-1:0]      iss_rob;
  logic [WAYS-1:0][PAYLOAD_W-1:0]  iss_payload;
  logic [CNT_W-1:0]                free_cnt;

  modport master (
    output disp_valid, disp_class, disp_src1, disp_src2, disp_rdy1, disp_rdy2,
           disp_rob, disp_payload, cdb_valid, cdb_tag, fu_budget, squash,
           squash_rob, rob_head,
    input  disp_ready, iss_valid, iss_class, iss_rob, iss_payload, free_cnt
  );

  modport slave (
    input  disp_valid, disp_class, disp_src1, disp_src2, disp_rdy1, disp_rdy2,
           disp_rob, disp_payload, cdb_valid, cdb_tag, fu_budget, squash,
           squash_rob, rob_head,
    output disp_ready, iss_valid, iss_class, iss_rob, iss_payload, free_cnt
  );
endinterface

// File: rtl/rs_age.sv
// Oldest-ready-first reservation station (age matrix, per-class FU budgets, ROB-relative squash);
// issue is combinational from state, dispatch needs free slots; RS_WAKEUP_BYPASS_EN adds CDB-to-issue bypass.
module rs_age #(
  parameter int N_ENTRIES = 16,
  parameter int WAYS      = 3,
  parameter int PR_W      = 6,
  parameter int ROB_W     = 5,
  parameter int N_CLASS   = 3,
  parameter int PAYLOAD_W = 128
) (
  input logic      clk,
  input logic      rst_n,
  rs_age_if.slave  bus
);
  localparam int CLS_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam int BUD_W = $clog2(WAYS + 1);
  localparam int CNT_W = $clog2(N_ENTRIES + 1);
  localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int N_BUD = 1 << CLS_W;

  typedef struct packed {
    logic [CLS_W-1:0]     cls;
    logic [PR_W-1:0]      src1;
    logic [PR_W-1:0]      src2;
    logic                 rdy1;
    logic                 rdy2;
    logic [ROB_W-1:0]     rob;
    logic [PAYLOAD_W-1:0] payload;
  } ent_t;

  ent_t                 ent_q [N_ENTRIES];
  ent_t                 ent_d [N_ENTRIES];
  logic [N_ENTRIES-1:0] vld_q, vld_d;
  logic [N_ENTRIES-1:0] age_q [N_ENTRIES];
  logic [N_ENTRIES-1:0] age_d [N_ENTRIES];
  logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;

  logic [N_ENTRIES-1:0] hit1, hit2, elig, iss_mask;
  logic [WAYS-1:0]      dhit1, dhit2, disp_rdy, sel_vld;
  logic [IDX_W-1:0]     sel_idx [WAYS];

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      hit1[i] = 1'b0;
      hit2[i] = 1'b0;
      for (int c = 0; c < WAYS; c++) begin
        if (bus.cdb_valid[c] && bus.cdb_tag[c] == ent_q[i].src1) hit1[i] = 1'b1;
        if (bus.cdb_valid[c] && bus.cdb_tag[c] == ent_q[i].src2) hit2[i] = 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      dhit1[w] = 1'b0;
      dhit2[w] = 1'b0;
      for (int c = 0; c < WAYS; c++) begin
        if (bus.cdb_valid[c] && bus.cdb_tag[c] == bus.disp_src1[w]) dhit1[w] = 1'b1;
        if (bus.cdb_valid[c] && bus.cdb_tag[c] == bus.disp_src2[w]) dhit2[w] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
      elig[i] = vld_q[i] & (ent_q[i].rdy1 | hit1[i]) & (ent_q[i].rdy2 | hit2[i]);
`else
      elig[i] = vld_q[i] & ent_q[i].rdy1 & ent_q[i].rdy2;
`endif
    end
  end

  // Each round takes the eligible entry with no older eligible competitor still in budget.
  always_comb begin
    logic [BUD_W-1:0]     bud_rem [N_BUD];
    logic [N_ENTRIES-1:0] taken;
    logic [N_ENTRIES-1:0] cand;
    logic                 older;
    for (int b = 0; b < N_BUD; b++) bud_rem[b] = '0;
    for (int c = 0; c < N_CLASS; c++) bud_rem[c] = bus.fu_budget[c];
    taken = '0;
    cand  = '0;
    older = 1'b0;
    for (int s = 0; s < WAYS; s++) begin
      sel_vld[s] = 1'b0;
      sel_idx[s] = '0;
      for (int i = 0; i < N_ENTRIES; i++)
        cand[i] = elig[i] & ~taken[i] & (bud_rem[ent_q[i].cls] != '0);
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (cand[i] && !sel_vld[s]) begin
          older = 1'b0;
          for (int j = 0; j < N_ENTRIES; j++)
            if (cand[j] && age_q[j][i]) older = 1'b1;
          if (!older) begin
            sel_vld[s] = 1'b1;
            sel_idx[s] = IDX_W'(i);
          end
        end
      end
      if (sel_vld[s]) begin
        taken[sel_idx[s]] = 1'b1;
        bud_rem[ent_q[sel_idx[s]].cls] = bud_rem[ent_q[sel_idx[s]].cls] - BUD_W'(1);
      end
    end
  end

  always_comb begin
    iss_mask = '0;
    for (int s = 0; s < WAYS; s++) begin
      bus.iss_valid[s]   = sel_vld[s] & ~bus.squash;
      bus.iss_class[s]   = '0;
      bus.iss_rob[s]     = '0;
      bus.iss_payload[s] = '0;
      if (bus.iss_valid[s]) begin
        bus.iss_class[s]   = ent_q[sel_idx[s]].cls;
        bus.iss_rob[s]     = ent_q[sel_idx[s]].rob;
        bus.iss_payload[s] = ent_q[sel_idx[s]].payload;
        iss_mask[sel_idx[s]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++)
      disp_rdy[w] = rst_n & ~bus.squash & (w < int'(free_cnt_q));
  end

  assign bus.disp_ready = disp_rdy;
  assign bus.free_cnt   = free_cnt_q;

  always_comb begin
    logic [N_ENTRIES-1:0] free_m;
    logic [N_ENTRIES-1:0] new_m;
    logic                 found;
    logic [ROB_W-1:0]     sq_dist;
    logic [ROB_W-1:0]     e_dist;
    vld_d = vld_q & ~iss_mask;
    for (int i = 0; i < N_ENTRIES; i++) begin
      age_d[i] = age_q[i];
      ent_d[i] = ent_q[i];
      if (hit1[i]) ent_d[i].rdy1 = 1'b1;
      if (hit2[i]) ent_d[i].rdy2 = 1'b1;
    end
    // Distances from the ROB head keep the ordering correct across index wrap.
    sq_dist = bus.squash_rob - bus.rob_head;
    e_dist  = '0;
    if (bus.squash) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        e_dist = ent_q[i].rob - bus.rob_head;
        if (e_dist > sq_dist) vld_d[i] = 1'b0;
      end
    end
    free_m = ~vld_q;
    new_m  = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      found = 1'b0;
      if (bus.disp_valid[w] && disp_rdy[w]) begin
        for (int e = 0; e < N_ENTRIES; e++) begin
          if (!found && free_m[e]) begin
            found          = 1'b1;
            free_m[e]      = 1'b0;
            vld_d[e]       = 1'b1;
            ent_d[e].cls     = bus.disp_class[w];
            ent_d[e].src1    = bus.disp_src1[w];
            ent_d[e].src2    = bus.disp_src2[w];
            ent_d[e].rdy1    = bus.disp_rdy1[w] | dhit1[w];
            ent_d[e].rdy2    = bus.disp_rdy2[w] | dhit2[w];
            ent_d[e].rob     = bus.disp_rob[w];
            ent_d[e].payload = bus.disp_payload[w];
            age_d[e] = '0;
            for (int j = 0; j < N_ENTRIES; j++)
              age_d[j][e] = vld_q[j] | new_m[j];
            new_m[e] = 1'b1;
          end
        end
      end
    end
    free_cnt_d = '0;
    for (int i = 0; i < N_ENTRIES; i++)
      if (!vld_d[i]) free_cnt_d = free_cnt_d + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      free_cnt_q <= CNT_W'(N_ENTRIES);
      for (int i = 0; i < N_ENTRIES; i++) begin
        ent_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      vld_q      <= vld_d;
      free_cnt_q <= free_cnt_d;
      for (int i = 0; i < N_ENTRIES; i++) begin
        ent_q[i] <= ent_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end
endmodule
